// File: rtl/pc_unit_if.sv
// pc_unit_if: control/next-PC bus between control unit and pc_unit.
interface pc_unit_if #(parameter int XLEN = 32);
  logic            pc_en;
  logic [1:0]      sel;
  logic [XLEN-1:0] br_off;
  logic [25:0]     j_target;
  logic [XLEN-1:0] jr_addr;
  logic            exc_req;
  logic [4:0]      exc_code;
  logic            eret;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] epc;
  logic [4:0]      cause;
  logic            in_exc;
  logic            exc_nested;
  logic            addr_err;
  modport master (
    output pc_en, sel, br_off, j_target, jr_addr, exc_req, exc_code, eret,
    input  pc, pc_plus4, epc, cause, in_exc, exc_nested, addr_err
  );
  modport slave (
    input  pc_en, sel, br_off, j_target, jr_addr, exc_req, exc_code, eret,
    output pc, pc_plus4, epc, cause, in_exc, exc_nested, addr_err
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: MIPS program counter with branch/jump/jr, wrap, stall and EPC/cause exceptions.
// Optional misaligned-redirect trap enabled by defining PC_ALIGN_CHK_EN.
module pc_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(32'h00000000),
  parameter logic [XLEN-1:0] EXC_VEC    = XLEN'(32'h00000100),
  parameter logic [XLEN-1:0] WRAP_LIMIT = XLEN'(32'h00000FFC)
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);
  typedef enum logic {RUN, EXC} state_t;
  state_t          state;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] nxt;
  logic            mis;
  assign bus.pc_plus4 = bus.pc + XLEN'(4);
  assign bus.in_exc   = state == EXC;
  always_comb begin
    raw = bus.sel == 2'd0 ? bus.pc_plus4 :
          bus.sel == 2'd1 ? bus.pc_plus4 + (bus.br_off << 2) :
          bus.sel == 2'd2 ? {bus.pc_plus4[XLEN-1:28], bus.j_target, 2'b00} :
                            bus.jr_addr;
    nxt = raw >= WRAP_LIMIT ? RESET_VEC : raw;
  end
`ifdef PC_ALIGN_CHK_EN
  assign mis = |nxt[1:0];
`else
  assign mis = 1'b0;
`endif
  // eret and the alignment trap share the else-path so a nested exc_req still falls through
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pc         <= RESET_VEC;
      bus.epc        <= '0;
      bus.cause      <= '0;
      bus.exc_nested <= 1'b0;
      bus.addr_err   <= 1'b0;
      state          <= RUN;
    end else begin
      bus.addr_err <= 1'b0;
      if (state == RUN && bus.exc_req) begin
        bus.epc   <= bus.pc;
        bus.cause <= bus.exc_code;
        bus.pc    <= EXC_VEC;
        state     <= EXC;
      end else begin
        if (state == EXC && bus.exc_req) bus.exc_nested <= 1'b1;
        if (state == EXC && bus.eret) begin
          bus.pc <= bus.epc;
          state  <= RUN;
        end else if (bus.pc_en && state == RUN && mis) begin
          bus.epc      <= bus.pc;
          bus.cause    <= 5'd4;
          bus.pc       <= EXC_VEC;
          bus.addr_err <= 1'b1;
          state        <= EXC;
        end else if (bus.pc_en) begin
          bus.pc <= nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed stimulus against a behavioural model plus literal expectations.
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   live = 1'b0;
  always #5 clk = ~clk;
  pc_unit_if #(.XLEN(32)) bus();
  pc_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  logic [31:0] m_pc, m_epc, m_nxt;
  logic [4:0]  m_cause;
  logic        m_exc, m_nested, m_ae, m_mis;
  function automatic logic [31:0] next_of(input logic [31:0] p, input logic [1:0] s,
      input logic [31:0] off, input logic [25:0] jt, input logic [31:0] ja);
    logic [31:0] seq = p + 32'd4;
    logic [31:0] c;
    case (s)
      2'd0:    c = seq;
      2'd1:    c = seq + off * 32'd4;
      2'd2:    c = (seq & 32'hF000_0000) | ({6'b0, jt} * 32'd4);
      default: c = ja;
    endcase
    return c >= 32'h0000_0FFC ? 32'h0 : c;
  endfunction
  assign m_nxt = next_of(m_pc, bus.sel, bus.br_off, bus.j_target, bus.jr_addr);
`ifdef PC_ALIGN_CHK_EN
  assign m_mis = (m_nxt % 4) != 0;
`else
  assign m_mis = 1'b0;
`endif
  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 0; m_epc <= 0; m_cause <= 0; m_exc <= 0; m_nested <= 0; m_ae <= 0;
      live <= 1'b1;
    end else begin
      m_ae <= 0;
      if (!m_exc && bus.exc_req) begin
        m_epc <= m_pc; m_cause <= bus.exc_code; m_pc <= 32'h100; m_exc <= 1;
      end else begin
        if (m_exc && bus.exc_req) m_nested <= 1;
        if (m_exc && bus.eret) begin
          m_pc <= m_epc; m_exc <= 0;
        end else if (bus.pc_en && !m_exc && m_mis) begin
          m_epc <= m_pc; m_cause <= 5'd4; m_pc <= 32'h100; m_exc <= 1; m_ae <= 1;
        end else if (bus.pc_en) begin
          m_pc <= m_nxt;
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (live) begin
    chk("model.pc", bus.pc, m_pc);
    chk("model.pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    chk("model.epc", bus.epc, m_epc);
    chk("model.cause", {27'b0, bus.cause}, {27'b0, m_cause});
    chk("model.in_exc", {31'b0, bus.in_exc}, {31'b0, m_exc});
    chk("model.exc_nested", {31'b0, bus.exc_nested}, {31'b0, m_nested});
    chk("model.addr_err", {31'b0, bus.addr_err}, {31'b0, m_ae});
  end
  task automatic go(input logic [1:0] s, input logic en, input logic [31:0] ja,
      input logic [31:0] off, input logic [25:0] jt, input logic xr, input logic [4:0] xc,
      input logic er);
    #1;
    rst = 0; bus.sel = s; bus.pc_en = en; bus.jr_addr = ja; bus.br_off = off;
    bus.j_target = jt; bus.exc_req = xr; bus.exc_code = xc; bus.eret = er;
    @(negedge clk);
  endtask
  initial begin
    rst = 1; bus.sel = 0; bus.pc_en = 1; bus.jr_addr = 0; bus.br_off = 0;
    bus.j_target = 0; bus.exc_req = 0; bus.exc_code = 0; bus.eret = 0;
    @(negedge clk); @(negedge clk);
    chk("rst.pc", bus.pc, 32'h0);
    chk("rst.in_exc", {31'b0, bus.in_exc}, 32'h0);
    go(0, 1, 0, 0, 0, 0, 0, 0); chk("seq1", bus.pc, 32'h4);
    go(0, 1, 0, 0, 0, 0, 0, 0); chk("seq2", bus.pc, 32'h8);
    go(0, 1, 0, 0, 0, 0, 0, 0); chk("seq3", bus.pc, 32'hC);
    go(3, 1, 32'h40, 0, 0, 0, 0, 0); chk("jr40", bus.pc, 32'h40);
    go(1, 1, 0, -32'sd2, 0, 0, 0, 0); chk("branch_back", bus.pc, 32'h3C);
    go(2, 1, 0, 0, 26'h10, 0, 0, 0); chk("jump", bus.pc, 32'h40);
    go(3, 1, 32'h200, 0, 0, 0, 0, 0); chk("jr200", bus.pc, 32'h200);
    go(3, 1, 32'hFF8, 0, 0, 0, 0, 0); chk("jrFF8", bus.pc, 32'hFF8);
    go(0, 1, 0, 0, 0, 0, 0, 0); chk("wrap", bus.pc, 32'h0);
    go(3, 1, 32'h10, 0, 0, 0, 0, 0); chk("jr10", bus.pc, 32'h10);
    go(0, 0, 0, 0, 0, 0, 0, 0); chk("stall1", bus.pc, 32'h10);
    go(0, 0, 0, 0, 0, 0, 0, 0); chk("stall2", bus.pc, 32'h10);
    go(3, 1, 32'h24, 0, 0, 0, 0, 0); chk("jr24", bus.pc, 32'h24);
    go(0, 1, 0, 0, 0, 1, 5'd12, 0);
    chk("exc.pc", bus.pc, 32'h100);
    chk("exc.epc", bus.epc, 32'h24);
    chk("exc.cause", {27'b0, bus.cause}, 32'd12);
    chk("exc.in_exc", {31'b0, bus.in_exc}, 32'h1);
    go(0, 1, 0, 0, 0, 0, 0, 0); chk("exc.seq1", bus.pc, 32'h104);
    go(0, 1, 0, 0, 0, 0, 0, 0); chk("exc.seq2", bus.pc, 32'h108);
    go(0, 1, 0, 0, 0, 0, 0, 1); chk("eret.pc", bus.pc, 32'h24);
    chk("eret.in_exc", {31'b0, bus.in_exc}, 32'h0);
    go(0, 0, 0, 0, 0, 1, 5'd3, 0); chk("exc_stalled.pc", bus.pc, 32'h100);
    go(0, 1, 0, 0, 0, 1, 5'd7, 0);
    chk("nested.flag", {31'b0, bus.exc_nested}, 32'h1);
    chk("nested.epc", bus.epc, 32'h24);
    chk("nested.cause", {27'b0, bus.cause}, 32'd3);
    chk("nested.pc", bus.pc, 32'h104);
    go(0, 0, 0, 0, 0, 0, 0, 1); chk("eret_stalled.pc", bus.pc, 32'h24);
    go(0, 1, 0, 0, 0, 0, 0, 1); chk("eret_in_run", bus.pc, 32'h28);
    go(0, 1, 0, 0, 0, 1, 5'd5, 0); chk("exc2.epc", bus.epc, 32'h28);
    go(0, 1, 0, 0, 0, 1, 5'd6, 1);
    chk("exc_eret.pc", bus.pc, 32'h28);
    chk("exc_eret.in_exc", {31'b0, bus.in_exc}, 32'h0);
    go(0, 1, 0, 0, 0, 1, 5'd9, 0); chk("exc3.pc", bus.pc, 32'h100);
    #1; rst = 1; bus.exc_req = 1; @(negedge clk);
    chk("rst_exc.pc", bus.pc, 32'h0);
    chk("rst_exc.in_exc", {31'b0, bus.in_exc}, 32'h0);
    chk("rst_exc.nested", {31'b0, bus.exc_nested}, 32'h0);
    chk("rst_exc.epc", bus.epc, 32'h0);
    go(3, 1, 32'h50, 0, 0, 0, 0, 0); chk("jr50", bus.pc, 32'h50);
    go(3, 1, 32'h62, 0, 0, 0, 0, 0);
`ifdef PC_ALIGN_CHK_EN
    chk("align.pc", bus.pc, 32'h100);
    chk("align.epc", bus.epc, 32'h50);
    chk("align.cause", {27'b0, bus.cause}, 32'd4);
    chk("align.addr_err", {31'b0, bus.addr_err}, 32'h1);
    go(0, 1, 0, 0, 0, 0, 0, 0);
    chk("align.pulse_end", {31'b0, bus.addr_err}, 32'h0);
    chk("align.exc_seq", bus.pc, 32'h104);
`else
    chk("noalign.pc", bus.pc, 32'h62);
    chk("noalign.addr_err", {31'b0, bus.addr_err}, 32'h0);
    go(0, 1, 0, 0, 0, 0, 0, 0); chk("noalign.seq", bus.pc, 32'h66);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-cycle MIPS core; generation after the basic PC register.
- Computes the next PC internally for sequential, branch, jump and jump-register flow.
- Supports stall, a programmable wrap limit, and precise exception entry/return with an EPC/cause register pair.
- Sits between the control unit and the instruction memory address port.

Parameters:
- XLEN, 32, PC/datapath width; must be >= 32.
- RESET_VEC, 32'h00000000, PC value loaded on reset and on wrap.
- EXC_VEC, 32'h00000100, exception handler entry address.
- WRAP_LIMIT, 32'h00000FFC, any computed next PC >= this value is replaced by RESET_VEC.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc_en  in  1  1 = advance; 0 = stall (hold pc).
- sel  in  2  next-PC source: 0 seq, 1 branch, 2 jump, 3 jump-register.
- br_off  in  XLEN  sign-extended branch word offset.
- j_target  in  26  jump instruction index.
- jr_addr  in  XLEN  register jump target.
- exc_req  in  1  exception request this cycle.
- exc_code  in  5  cause code accompanying exc_req.
- eret  in  1  return from exception.
- pc  out  XLEN  current PC (registered).
- pc_plus4  out  XLEN  pc + 4, combinational.
- epc  out  XLEN  saved exception PC (registered).
- cause  out  5  saved cause code (registered).
- in_exc  out  1  1 while in EXC state.
- exc_nested  out  1  sticky: exc_req seen while in EXC.
- addr_err  out  1  registered; 1 for one cycle after a misaligned redirect was trapped (only with the optional feature).

Behaviour:
- Reset: pc=RESET_VEC, epc=0, cause=0, in_exc=0, exc_nested=0, addr_err=0, state RUN. Reset overrides all other inputs on that edge.
- FSM states:
  - RUN to EXC on exc_req.
  - EXC to RUN on eret.
  - No other transitions.
- Arithmetic is modulo 2^XLEN.
- pc_plus4 = pc + 4.
- Next-PC candidate, nxt:
  - sel=0: pc_plus4.
  - sel=1: pc_plus4 + (br_off << 2).
  - sel=2: {pc_plus4[XLEN-1:28], j_target, 2'b00}.
  - sel=3: jr_addr.
- Wrap: if nxt >= WRAP_LIMIT (unsigned), nxt becomes RESET_VEC.
- Priority per rising edge, highest first:
  1. rst.
  2. exc_req while in RUN: epc<=pc, cause<=exc_code, pc<=EXC_VEC, go to EXC. Applies even if pc_en=0.
  3. exc_req while in EXC: exc_nested<=1, request otherwise ignored (falls through).
  4. eret while in EXC: pc<=epc, go to RUN. Applies even if pc_en=0.
  5. eret while in RUN: ignored.
  6. pc_en=0: pc holds, epc/cause unchanged.
  7. Otherwise pc<=nxt.
- Simultaneous exc_req and eret in EXC: eret is taken and exc_nested is set.
- Latency: every update is visible on pc one cycle after the edge; no bubbles.
- epc/cause are written only on exception entry and persist through eret.
- Reset mid-exception returns to RUN with all state cleared.

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- When defined:
  - In RUN with pc_en=1, if the selected nxt (after wrap) has nxt[1:0] != 0, treat it as an internal exception: epc<=pc, cause<=5'd4, pc<=EXC_VEC, go to EXC, addr_err<=1 for one cycle.
  - External exc_req has priority over this check; a misaligned nxt in EXC is not checked.
- When undefined:
  - nxt is loaded unmodified, including low bits.
  - addr_err is tied 0.

Test Plan:
- Reset release, sel=0, pc_en=1 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC.
- At pc=0x40: sel=1, br_off=-2 -> pc=0x3C. Then sel=2, j_target=0x10 -> pc=0x40. Then sel=3, jr_addr=0x200 -> pc=0x200.
- pc=0xFF8, sel=0 -> pc=0x000 (wrap). Also pc_en=0 for 2 cycles at pc=0x10 -> pc stays 0x10.
- At pc=0x24: exc_req=1, exc_code=12 -> pc=0x100, epc=0x24, cause=12, in_exc=1. Two seq cycles -> 0x104, 0x108. eret -> pc=0x24, in_exc=0.
- In EXC: exc_req=1 -> exc_nested=1, epc unchanged. eret during pc_en=0 -> still returns. rst during EXC -> pc=0, in_exc=0, exc_nested=0.
- PC_ALIGN_CHK_EN defined, pc=0x50, sel=3, jr_addr=0x62 -> pc=0x100, epc=0x50, cause=4, addr_err pulses 1 cycle. Macro undefined, same stimulus -> pc=0x62.
